// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control slice.
//   pipe_state_e    : hazard controller state encoding
//   INST_NOP        : instruction word loaded on flush/bubble
//   DEF_REG_ADDR_W  : default register-specifier width
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } pipe_state_e;

  localparam logic [31:0] INST_NOP       = 32'h0;
  localparam int          DEF_REG_ADDR_W = 5;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detector.
//   id_rs_i/id_rt_i        : source specifiers of the instruction in ID
//   id_uses_rs_i/_rt_i     : ID instruction actually reads rs / rt
//   ex_mem_read_i, ex_rd_i : EX instruction is a load, and its destination
//   lu_o                   : ID must wait one cycle for the load result
module hazard_detect #(
  parameter int REG_ADDR_W = pipe_ctrl_pkg::DEF_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  id_uses_rs_i,
  input  logic                  id_uses_rt_i,
  input  logic                  ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  output logic                  lu_o
);

  logic rs_hit, rt_hit;

  assign rs_hit = id_uses_rs_i && (id_rs_i == ex_rd_i);
  assign rt_hit = id_uses_rt_i && (id_rt_i == ex_rd_i);
  // $zero is never a real dependency
  assign lu_o   = ex_mem_read_i && (ex_rd_i != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
//   clk, rst_b            : clock, synchronous active-high reset
//   id_*/ex_*             : operand/destination info for load-use detection
//   branch_taken_ex       : taken branch in EX squashes IF/ID and ID/EX
//   halted_controller_id  : halt instruction sitting in ID
//   imem_ready/dmem_ready : memory handshakes (dmem_ready=1 when idle)
//   lock_*                : hold PC / pipeline registers
//   flush_if_id           : load NOP into IF/ID
//   bubble_id_ex          : load NOP into ID/EX
//   halted                : core frozen after the halt retired
// Outputs are combinational from state + inputs; state and counters registered.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LOAD_USE_STALL = 1,
  parameter int DRAIN_CYCLES   = 3,
  parameter int REG_ADDR_W     = DEF_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  branch_taken_ex,
  input  logic                  halted_controller_id,
  input  logic                  imem_ready,
  input  logic                  dmem_ready,
  output logic                  lock_pc,
  output logic                  lock_if_id,
  output logic                  lock_id_ex,
  output logic                  lock_ex_mem,
  output logic                  lock_mem_wb,
  output logic                  flush_if_id,
  output logic                  bubble_id_ex,
  output logic                  halted
);

  localparam int SCW = (LOAD_USE_STALL < 1) ? 1 : $clog2(LOAD_USE_STALL + 1);
  localparam int DCW = (DRAIN_CYCLES   < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  pipe_state_e    state_q, state_d;
  logic [SCW-1:0] stall_cnt_q, stall_cnt_d;
  logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
  logic           lu;

  hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard_detect (
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .id_uses_rs_i  (id_uses_rs),
    .id_uses_rt_i  (id_uses_rt),
    .ex_mem_read_i (ex_mem_read),
    .ex_rd_i       (ex_rd),
    .lu_o          (lu)
  );

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    stall_cnt_d  = stall_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    lock_pc      = 1'b0;
    lock_if_id   = 1'b0;
    lock_id_ex   = 1'b0;
    lock_ex_mem  = 1'b0;
    lock_mem_wb  = 1'b0;
    flush_if_id  = 1'b0;
    bubble_id_ex = 1'b0;
    halted       = 1'b0;

    if (state_q == HALTED) begin
      // terminal: only reset leaves
      {lock_pc, lock_if_id, lock_id_ex, lock_ex_mem, lock_mem_wb} = '1;
      halted = 1'b1;
    end else if (!dmem_ready) begin
      // whole pipe waits on data memory; state and counters frozen
      {lock_pc, lock_if_id, lock_id_ex, lock_ex_mem, lock_mem_wb} = '1;
    end else if (branch_taken_ex) begin
      // wrong-path squash also cancels a pending stall or halt drain
      flush_if_id  = 1'b1;
      bubble_id_ex = 1'b1;
      state_d      = RUN;
      stall_cnt_d  = '0;
      drain_cnt_d  = '0;
    end else begin
      case (state_q)
        DRAIN: begin
          // fetch is dead, older instructions retire; imem_ready is irrelevant
          lock_pc     = 1'b1;
          flush_if_id = 1'b1;
          if (drain_cnt_q != '0) drain_cnt_d = drain_cnt_q - 1'b1;
          if (drain_cnt_q <= DCW'(1)) state_d = HALTED;
        end
        LU_STALL: begin
          lock_pc      = 1'b1;
          lock_if_id   = 1'b1;
          bubble_id_ex = 1'b1;
          if (stall_cnt_q != '0) stall_cnt_d = stall_cnt_q - 1'b1;
          if (stall_cnt_q <= SCW'(1)) state_d = RUN;
        end
        default: begin
          if (lu) begin
            // IF/ID already held, so an imem miss this cycle needs no flush
            lock_pc      = 1'b1;
            lock_if_id   = 1'b1;
            bubble_id_ex = 1'b1;
            if (LOAD_USE_STALL > 1) begin
              state_d     = LU_STALL;
              stall_cnt_d = SCW'(LOAD_USE_STALL - 1);
            end
          end else if (halted_controller_id) begin
            // halt itself advances out of ID this cycle
            state_d     = DRAIN;
            drain_cnt_d = DCW'(DRAIN_CYCLES);
          end else if (!imem_ready) begin
            lock_pc     = 1'b1;
            flush_if_id = 1'b1;
          end
        end
      endcase
    end

    // reset forces quiet outputs regardless of current state
    if (rst_b) begin
      lock_pc      = 1'b0;
      lock_if_id   = 1'b0;
      lock_id_ex   = 1'b0;
      lock_ex_mem  = 1'b0;
      lock_mem_wb  = 1'b0;
      flush_if_id  = 1'b0;
      bubble_id_ex = 1'b0;
      halted       = 1'b0;
    end
  end

endmodule
